// File: rtl/itof_pipe_if.sv
// Handshake bundle between the integer register-read stage, the itof_pipe
// converter and FPU writeback. The producer/consumer side uses the master
// modport; the converter uses the slave modport.
interface itof_pipe_if #(
  parameter int IN_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic                in_signed;
  logic                in_rm;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic                out_inexact;

  modport master (
    output in_valid, in_data, in_signed, in_rm, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_rm, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage integer to binary32 converter.
//   S1: sign / magnitude      S2: normalise      S3: round and pack
// A single advance enable moves every stage together; when the result in S3
// is stalled by the consumer, the whole pipe holds and in_ready drops.
module itof_pipe #(
  parameter int IN_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rstn,
  itof_pipe_if.slave  bus
);

  // Bits of the normalised magnitude below the leading one.
  localparam int FW = IN_WIDTH - 1;
  // Those bits padded with zeros so the 23-bit fraction, guard and sticky
  // slices stay in range even for narrow operands.
  localparam int XW = FW + 25;

  if (IN_WIDTH < 2 || IN_WIDTH > 64) begin : g_width_check
    $error("itof_pipe: IN_WIDTH must be in 2..64");
  end

  logic adv;

  logic                s1_valid_q;
  logic                s1_sign_q;
  logic                s1_rm_q;
  logic [IN_WIDTH-1:0] s1_mag_q;
  logic                s1_sign_d;
  logic [IN_WIDTH-1:0] s1_mag_d;

  logic                s2_valid_q;
  logic                s2_sign_q;
  logic                s2_rm_q;
  logic                s2_zero_q;
  logic [6:0]          s2_exp_q;
  logic [FW-1:0]       s2_frac_q;
  logic                s2_zero_d;
  logic [6:0]          s2_exp_d;
  logic [FW-1:0]       s2_frac_d;
  logic [6:0]          lz;
  logic [IN_WIDTH-1:0] norm;

  logic                s3_valid_q;
  logic                s3_inexact_q;
  logic [31:0]         s3_data_q;
  logic                s3_inexact_d;
  logic [31:0]         s3_data_d;
  logic [XW-1:0]       ext;
  logic [22:0]         frac_t;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [23:0]         sum;
  logic [7:0]          bexp;

  // Global advance: the pipe moves unless a finished result is waiting.
  always_comb begin
    adv          = !s3_valid_q || bus.out_ready;
    bus.in_ready = adv;
    bus.out_valid   = s3_valid_q;
    bus.out_data    = s3_data_q;
    bus.out_inexact = s3_inexact_q;
  end

  // S1 next state: sign and two's-complement absolute value (min wraps to 2^(W-1)).
  always_comb begin
    s1_sign_d = bus.in_signed & bus.in_data[IN_WIDTH-1];
    s1_mag_d  = s1_sign_d ? (~bus.in_data + 1'b1) : bus.in_data;
  end

  // S1 register: loads in_valid so bubbles travel with the data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_rm_q    <= 1'b0;
      s1_mag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_sign_q  <= s1_sign_d;
      s1_rm_q    <= bus.in_rm;
      s1_mag_q   <= s1_mag_d;
    end
  end

  // S2 next state: MSB position gives the exponent; shift it up to the top.
  always_comb begin
    s2_exp_d = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag_q[i]) s2_exp_d = 7'(i);
    end
    lz        = 7'(IN_WIDTH - 1) - s2_exp_d;
    norm      = s1_mag_q << lz;
    // After normalisation the top bit is clear only for a zero magnitude.
    s2_zero_d = ~norm[IN_WIDTH-1];
    s2_frac_d = norm[FW-1:0];
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_rm_q    <= 1'b0;
      s2_zero_q  <= 1'b1;
      s2_exp_q   <= '0;
      s2_frac_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_rm_q    <= s1_rm_q;
      s2_zero_q  <= s2_zero_d;
      s2_exp_q   <= s2_exp_d;
      s2_frac_q  <= s2_frac_d;
    end
  end

  // S3 next state: round to 23 fraction bits and pack.
  always_comb begin
    ext      = {s2_frac_q, 25'b0};
    frac_t   = ext[XW-1 -: 23];
    guard    = ext[XW-24];
    sticky   = |ext[XW-25:0];
    round_up = ~s2_rm_q & guard & (sticky | frac_t[0]);
    sum      = {1'b0, frac_t} + {23'b0, round_up};
    // A carry out leaves sum[22:0] all zero, which is the cleared fraction.
    bexp     = {1'b0, s2_exp_q} + 8'd127 + {7'b0, sum[23]};
    s3_data_d    = s2_zero_q ? 32'h0000_0000 : {s2_sign_q, bexp, sum[22:0]};
    s3_inexact_d = ~s2_zero_q & (guard | sticky);
  end

  // S3 register: the visible result, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s3_valid_q   <= 1'b0;
      s3_inexact_q <= 1'b0;
      s3_data_q    <= '0;
    end else if (adv) begin
      s3_valid_q   <= s2_valid_q;
      s3_inexact_q <= s3_inexact_d;
      s3_data_q    <= s3_data_d;
    end
  end

endmodule
